// File: rtl/stack_ctrl.sv
// stack_ctrl: hardware stack for the 8-bit processor.
// Owns the stack storage and the stack pointer, and executes the
// SP_INC / SP_DEC / STACK_IN / STACK_OUT strobes that the control unit
// issues during PUSH and POP. The flags let the control unit gate the
// second step of each sequence. The read path is combinational so the
// top of stack reaches the shared data bus in the same cycle.
module stack_ctrl #(
  parameter int WIDTH = 8,  // data width of one stack entry
  parameter int DEPTH = 8,  // number of entries
  parameter int PW    = 4   // pointer width; 2**PW must exceed DEPTH
) (
  input  logic             Clk,
  input  logic             Rst,        // asynchronous, active-low
  input  logic             SP_INC,
  input  logic             SP_DEC,
  input  logic             STACK_IN,
  input  logic             STACK_OUT,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_en,
  output logic             overflow,
  output logic             empty,
  output logic             underflow,
  output logic [PW-1:0]    SP,
  output logic [PW-1:0]    hwm
);

  // Pointer and flag state.
  logic [PW-1:0] sp_q, sp_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] hwm_q, hwm_d;

  // Storage; deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // One-hot decode of the top entry: bit gi is set when SP == gi+1,
  // so an empty stack selects nothing.
  logic [DEPTH-1:0] top_sel;
  logic             is_empty;
  logic             is_full;
  logic             wr_en;
  logic [WIDTH-1:0] rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_top_sel
      assign top_sel[gi] = (sp_q == PW'(gi + 1));
    end
  endgenerate

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q >= PW'(DEPTH));

  // A write is dropped when there is no top entry or when the preceding
  // SP_INC was rejected; it always targets the pre-edge top.
  assign wr_en = STACK_IN && !is_empty && !overflow_q;

  // Combinational top-of-stack read; yields zero when empty.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_sel[i]) begin
        rd_data = mem_q[i];
      end
    end
  end

  // Next-state rules for the pointer, flags and high-water mark.
  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    case ({SP_INC, SP_DEC})
      2'b11: begin
        // Conflicting strobes: pointer held, reported via underflow.
        underflow_d = 1'b1;
      end
      2'b10: begin
        if (!is_full) begin
          sp_d       = sp_q + PW'(1);
          overflow_d = 1'b0;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          sp_d       = sp_q - PW'(1);
          overflow_d = 1'b0;
        end else begin
          underflow_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // Reading an empty stack is also an underflow.
    if (STACK_OUT && is_empty) begin
      underflow_d = 1'b1;
    end

    hwm_d = (sp_d > hwm_q) ? sp_d : hwm_q;
  end

  // Pointer and flag registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      hwm_q       <= '0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      hwm_q       <= hwm_d;
    end
  end

  // Storage write into the pre-edge top entry.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (top_sel[i]) begin
          mem_q[i] <= Din;
        end
      end
    end
  end

  assign Dout      = STACK_OUT ? rd_data : '0;
  assign Dout_en   = STACK_OUT;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign empty     = is_empty;
  assign SP        = sp_q;
  assign hwm       = hwm_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed vector table, hand-written reset
// sequences, then randomized strobes checked against a stack model.
module tb_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sp_inc = 1'b0;
  logic             sp_dec = 1'b0;
  logic             st_in = 1'b0;
  logic             st_out = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_en;
  logic             ovf;
  logic             emp;
  logic             unf;
  logic [PW-1:0]    sp;
  logic [PW-1:0]    hwm;

  int vectors = 0;
  int miscompares = 0;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) dut (
    .Clk(clk), .Rst(rst_n), .SP_INC(sp_inc), .SP_DEC(sp_dec),
    .STACK_IN(st_in), .STACK_OUT(st_out), .Din(din), .Dout(dout),
    .Dout_en(dout_en), .overflow(ovf), .empty(emp), .underflow(unf),
    .SP(sp), .hwm(hwm)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;
    bit         inc;
    bit         dec;
    bit         sin;
    bit         sout;
    logic [7:0] din;
    logic [7:0] dout;
    int         sp;
    bit         ovf;
    bit         unf;
    int         hwm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit r, bit i, bit d, bit wi, bit ro,
                                  logic [7:0] dn, logic [7:0] dq,
                                  int s, bit o, bit u, int h);
    vec_t t;
    t.rst = r; t.inc = i; t.dec = d; t.sin = wi; t.sout = ro;
    t.din = dn; t.dout = dq; t.sp = s; t.ovf = o; t.unf = u; t.hwm = h;
    vecs.push_back(t);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Behavioural stack model for the random phase.
  logic [7:0] rm [DEPTH];
  bit         known [DEPTH];
  int         rsp, rhwm;
  bit         rovf, runf;

  function automatic void model_reset();
    rsp = 0; rhwm = 0; rovf = 0; runf = 0;
  endfunction

  function automatic void model_edge(bit i, bit d, bit wi, bit ro, logic [7:0] dn);
    int old_sp;
    old_sp = rsp;
    if (wi && old_sp > 0 && !rovf) begin
      rm[old_sp-1] = dn;
      known[old_sp-1] = 1'b1;
    end
    if (i && d) runf = 1;
    else if (i) begin
      if (rsp < DEPTH) begin rsp = rsp + 1; rovf = 0; end
      else rovf = 1;
    end else if (d) begin
      if (rsp > 0) begin rsp = rsp - 1; rovf = 0; end
      else runf = 1;
    end
    if (ro && old_sp == 0) runf = 1;
    if (rsp > rhwm) rhwm = rsp;
  endfunction

  task automatic drive(bit i, bit d, bit wi, bit ro, logic [7:0] dn);
    sp_inc = i; sp_dec = d; st_in = wi; st_out = ro; din = dn;
  endtask

  int prev_sp;

  initial begin
    // ---------------- vector table ----------------
    // single push/pop of 0x3C
    add_vec(0,1,0,0,0,8'h00,8'h00,1,0,0,1);
    add_vec(0,0,0,1,0,8'h3C,8'h00,1,0,0,1);
    add_vec(0,0,0,0,1,8'h00,8'h3C,1,0,0,1);
    add_vec(0,0,1,0,0,8'h00,8'h00,0,0,0,1);
    // fill with 1..8
    for (int k = 1; k <= DEPTH; k++) begin
      add_vec(0,1,0,0,0,8'h00,8'h00,k,0,0,k);
      add_vec(0,0,0,1,0,8'(k),8'h00,k,0,0,k);
    end
    // ninth push rejected, write of 0xFF dropped
    add_vec(0,1,0,0,0,8'h00,8'h00,8,1,0,8);
    add_vec(0,0,0,1,0,8'hFF,8'h00,8,1,0,8);
    // drain, checking every value
    for (int k = DEPTH; k >= 1; k--) begin
      add_vec(0,0,0,0,1,8'h00,8'(k),k,(k == DEPTH),0,8);
      add_vec(0,0,1,0,0,8'h00,8'h00,k-1,0,0,8);
    end
    // pop from empty: underflow sticks
    add_vec(0,0,0,0,1,8'h00,8'h00,0,0,1,8);
    add_vec(0,0,1,0,0,8'h00,8'h00,0,0,1,8);
    add_vec(0,0,0,0,0,8'h00,8'h00,0,0,1,8);
    add_vec(0,0,0,0,0,8'h00,8'h00,0,0,1,8);
    // after reset: push 0x11,0x22,0x33
    add_vec(1,1,0,0,0,8'h00,8'h00,1,0,0,1);
    add_vec(0,0,0,1,0,8'h11,8'h00,1,0,0,1);
    add_vec(0,1,0,0,0,8'h00,8'h00,2,0,0,2);
    add_vec(0,0,0,1,0,8'h22,8'h00,2,0,0,2);
    add_vec(0,1,0,0,0,8'h00,8'h00,3,0,0,3);
    add_vec(0,0,0,1,0,8'h33,8'h00,3,0,0,3);
    // simultaneous inc+dec
    add_vec(0,1,1,0,0,8'h00,8'h00,3,0,1,3);
    // write and read together: old top shown, then new value
    add_vec(0,0,0,1,1,8'hAA,8'h33,3,0,1,3);
    add_vec(0,0,0,0,1,8'h00,8'hAA,3,0,1,3);
    // write with same-cycle inc lands on pre-edge top
    add_vec(0,1,0,1,0,8'h44,8'h00,4,0,1,4);
    add_vec(0,0,0,0,1,8'h00,8'h04,4,0,1,4);
    add_vec(0,0,1,0,0,8'h00,8'h00,3,0,1,4);
    add_vec(0,0,0,0,1,8'h00,8'h44,3,0,1,4);

    // ---------------- reset state ----------------
    drive(0,0,0,1,8'h00);
    repeat (2) @(negedge clk);
    chk("rst_dout_held", dout, 0);
    chk("rst_douten_held", dout_en, 1);
    rst_n = 1'b1;
    #1;
    chk("rst_sp", sp, 0);
    chk("rst_empty", emp, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_hwm", hwm, 0);
    drive(0,0,0,0,8'h00);
    #1;
    chk("rst_dout", dout, 0);
    $display("reset check done: sp=%0d empty=%0b", sp, emp);

    // ---------------- table ----------------
    prev_sp = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("v%0d_async_rst", i), sp, 0);
        rst_n = 1'b1;
        prev_sp = 0;
      end
      drive(vecs[i].inc, vecs[i].dec, vecs[i].sin, vecs[i].sout, vecs[i].din);
      #1;
      chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d_douten", i), dout_en, vecs[i].sout);
      chk($sformatf("v%0d_empty", i), emp, (prev_sp == 0));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_unf", i), unf, vecs[i].unf);
      chk($sformatf("v%0d_hwm", i), hwm, vecs[i].hwm);
      $display("vec %0d: inc=%0b dec=%0b in=%0b out=%0b din=%02h dout=%02h sp=%0d ovf=%0b unf=%0b hwm=%0d",
               i, vecs[i].inc, vecs[i].dec, vecs[i].sin, vecs[i].sout,
               vecs[i].din, vecs[i].dout, sp, ovf, unf, hwm);
      prev_sp = vecs[i].sp;
    end

    // ---------------- mid-push reset ----------------
    @(negedge clk);
    drive(1,0,0,0,8'h00);
    @(posedge clk); #1;
    chk("midrst_step1_sp", sp, 4);
    @(negedge clk);
    drive(0,0,0,0,8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_async_sp", sp, 0);
    chk("midrst_async_hwm", hwm, 0);
    chk("midrst_async_empty", emp, 1);
    rst_n = 1'b1;
    drive(0,0,1,0,8'h5A);
    @(posedge clk); #1;
    chk("midrst_in_sp", sp, 0);
    chk("midrst_in_empty", emp, 1);
    chk("midrst_in_hwm", hwm, 0);
    chk("midrst_in_ovf", ovf, 0);
    chk("midrst_in_unf", unf, 0);
    @(negedge clk);
    drive(0,0,0,1,8'h00);
    #1;
    chk("midrst_read_dout", dout, 0);
    @(posedge clk); #1;
    chk("midrst_read_unf", unf, 1);
    $display("mid-push reset done: sp=%0d empty=%0b unf=%0b", sp, emp, unf);

    // ---------------- randomized vs model ----------------
    @(negedge clk);
    drive(0,0,0,0,8'h00);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      int r, pu, pd;
      bit i_b, d_b, wi_b, ro_b;
      logic [7:0] dn;
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
      end
      if (((n / 150) % 2) == 0) begin pu = 40; pd = 20; end
      else begin pu = 20; pd = 40; end
      r = $urandom_range(0, 99);
      i_b = 0; d_b = 0;
      if (r < 3) begin i_b = 1; d_b = 1; end
      else if (r < 3 + pu) i_b = 1;
      else if (r < 3 + pu + pd) d_b = 1;
      wi_b = ($urandom_range(0, 99) < 40);
      ro_b = ($urandom_range(0, 99) < 40);
      dn = 8'($urandom);
      drive(i_b, d_b, wi_b, ro_b, dn);
      #1;
      if (!ro_b || rsp == 0) chk($sformatf("r%0d_dout", n), dout, 0);
      else if (known[rsp-1]) chk($sformatf("r%0d_dout", n), dout, rm[rsp-1]);
      chk($sformatf("r%0d_douten", n), dout_en, ro_b);
      chk($sformatf("r%0d_empty", n), emp, (rsp == 0));
      model_edge(i_b, d_b, wi_b, ro_b, dn);
      @(posedge clk); #1;
      chk($sformatf("r%0d_sp", n), sp, rsp);
      chk($sformatf("r%0d_ovf", n), ovf, rovf);
      chk($sformatf("r%0d_unf", n), unf, runf);
      chk($sformatf("r%0d_hwm", n), hwm, rhwm);
      $display("rnd %0d: inc=%0b dec=%0b in=%0b out=%0b din=%02h sp=%0d ovf=%0b unf=%0b hwm=%0d",
               n, i_b, d_b, wi_b, ro_b, dn, sp, ovf, unf, hwm);
    end

    @(negedge clk);
    drive(0,0,0,0,8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
